// File: rtl/delivery_sequencer.sv
// delivery_sequencer
//   Queues up to DEPTH coloured objects at the dock, delivers them in order
//   along one outbound pass, U-turns, returns and reverses into the dock.
//   MATCH, UTURN, REVERSE and EOT are guarded by a watchdog; expiry latches
//   FAULT until fault_clr.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   hall                hall sensor (async, low = hand present)
//   start, fault_clr    single-cycle command pulses
//   object_color        colour at the dock sensor
//   station_color       colour at the station sensor
//   end_of_track, uturn_finished, brake_finished,
//   reverse_finished, buzz_finished    actuator feedback levels
//   en_*                actuator enables (registered)
//   ssd_state           display code of the current state
//   cur_color           head-of-queue colour, 0 when queue empty
//   queue_count         items queued
//   undelivered         items dropped by the last end-of-track abort
//   fault               high while in FAULT
module delivery_sequencer #(
    parameter int COLOR_W = 2,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 50000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hall,
    input  logic                     start,
    input  logic                     fault_clr,
    input  logic [COLOR_W-1:0]       object_color,
    input  logic [COLOR_W-1:0]       station_color,
    input  logic                     end_of_track,
    input  logic                     uturn_finished,
    input  logic                     brake_finished,
    input  logic                     reverse_finished,
    input  logic                     buzz_finished,
    output logic                     en_tracking,
    output logic                     en_uturn,
    output logic                     en_brake,
    output logic                     en_reverse,
    output logic                     en_buzz,
    output logic                     en_object,
    output logic                     en_station,
    output logic [3:0]               ssd_state,
    output logic [COLOR_W-1:0]       cur_color,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic [$clog2(DEPTH):0]   undelivered,
    output logic                     fault
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

    localparam logic [8:0] S_READY   = 9'b000000001;
    localparam logic [8:0] S_NOCOLOR = 9'b000000010;
    localparam logic [8:0] S_SEND    = 9'b000000100;
    localparam logic [8:0] S_MATCH   = 9'b000001000;
    localparam logic [8:0] S_EOT     = 9'b000010000;
    localparam logic [8:0] S_UTURN   = 9'b000100000;
    localparam logic [8:0] S_RETURN  = 9'b001000000;
    localparam logic [8:0] S_REVERSE = 9'b010000000;
    localparam logic [8:0] S_FAULT   = 9'b100000000;

    logic [8:0]         state, state_nxt;
    logic               hall_p0, hall_p1, hall_p2;
    logic               hall_fall;
    logic [COLOR_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               returning;
    logic [WD_W-1:0]    wd_cnt;
    logic               wd_expired;
    logic               push, pop, flush;
    logic               clr_undeliv, load_undeliv;
    logic               set_ret, clr_ret;
    logic               o_tracking, o_uturn, o_brake, o_reverse, o_buzz, o_object, o_station, o_fault;
    logic [3:0]         o_ssd;

    // hall_p0/p1 synchronise; hall_p2 holds the previous synchronised level
    assign hall_fall   = hall_p2 & ~hall_p1;
    assign full        = (count == CW'(DEPTH));
    assign cur_color   = (count != '0) ? mem[rd_ptr] : '0;
    assign queue_count = count;
    assign wd_expired  = (wd_cnt == WD_LIMIT);

    always_comb begin
        state_nxt    = state;
        push         = 1'b0;
        pop          = 1'b0;
        flush        = 1'b0;
        clr_undeliv  = 1'b0;
        load_undeliv = 1'b0;
        set_ret      = 1'b0;
        clr_ret      = 1'b0;
        case (state)
            S_READY: begin
                // a dock event outranks a start arriving in the same cycle
                if (hall_fall) begin
                    if (object_color != '0 && !full) push = 1'b1;
                    else                              state_nxt = S_NOCOLOR;
                end else if (start) begin
                    clr_undeliv = 1'b1;
                    state_nxt   = (count != '0) ? S_SEND : S_NOCOLOR;
                end
            end
            S_NOCOLOR: if (buzz_finished) state_nxt = S_READY;
            S_SEND: begin
                if (station_color == cur_color) state_nxt = S_MATCH;
                else if (end_of_track)          state_nxt = S_EOT;
            end
            S_MATCH: begin
                if (hall_fall) begin
                    pop = 1'b1;
                    if (count > CW'(1)) begin
                        state_nxt = S_SEND;
                    end else begin
                        state_nxt = S_UTURN;
                        clr_ret   = 1'b1;
                    end
                end else if (wd_expired) begin
                    state_nxt = S_FAULT;
                end
            end
            S_EOT: begin
                if (buzz_finished && brake_finished) begin
                    state_nxt = S_UTURN;
                    clr_ret   = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = S_FAULT;
                end
            end
            S_UTURN: begin
                if (uturn_finished) state_nxt = returning ? S_REVERSE : S_RETURN;
                else if (wd_expired) state_nxt = S_FAULT;
            end
            S_RETURN: begin
                set_ret = 1'b1;
                if (end_of_track) state_nxt = S_UTURN;
            end
            S_REVERSE: begin
                if (reverse_finished) begin
                    state_nxt = S_READY;
                    clr_ret   = 1'b1;
                end else if (wd_expired) begin
                    state_nxt = S_FAULT;
                end
            end
            S_FAULT: if (fault_clr) state_nxt = S_READY;
            default: state_nxt = S_READY;
        endcase
        // EOT and FAULT both discard the queue as they are entered
        if (state_nxt != state && (state_nxt == S_EOT || state_nxt == S_FAULT)) flush = 1'b1;
        if (state_nxt != state && state_nxt == S_EOT) load_undeliv = 1'b1;
    end

    // Output decode of the next state, registered so outputs move with the state
    always_comb begin
        o_tracking = 1'b0;
        o_uturn    = 1'b0;
        o_brake    = 1'b0;
        o_reverse  = 1'b0;
        o_buzz     = 1'b0;
        o_object   = 1'b0;
        o_station  = 1'b0;
        o_fault    = 1'b0;
        o_ssd      = 4'h0;
        case (state_nxt)
            S_READY:   begin o_object = 1'b1; o_ssd = 4'h0; end
            S_NOCOLOR: begin o_object = 1'b1; o_buzz = 1'b1; o_ssd = 4'hE; end
            S_SEND:    begin o_tracking = 1'b1; o_station = 1'b1; o_ssd = 4'h1; end
            S_MATCH:   begin o_brake = 1'b1; o_buzz = 1'b1; o_ssd = 4'h2; end
            S_EOT:     begin o_brake = 1'b1; o_buzz = 1'b1; o_ssd = 4'h7; end
            S_UTURN:   begin o_uturn = 1'b1; o_ssd = 4'h8; end
            S_RETURN:  begin o_tracking = 1'b1; o_ssd = 4'h9; end
            S_REVERSE: begin o_reverse = 1'b1; o_ssd = 4'hA; end
            S_FAULT:   begin o_buzz = 1'b1; o_fault = 1'b1; o_ssd = 4'hF; end
            default:   begin o_object = 1'b1; o_ssd = 4'h0; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_READY;
            hall_p0     <= 1'b1;
            hall_p1     <= 1'b1;
            hall_p2     <= 1'b1;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            undelivered <= '0;
            returning   <= 1'b0;
            wd_cnt      <= '0;
            en_tracking <= 1'b0;
            en_uturn    <= 1'b0;
            en_brake    <= 1'b0;
            en_reverse  <= 1'b0;
            en_buzz     <= 1'b0;
            en_object   <= 1'b1;
            en_station  <= 1'b0;
            ssd_state   <= 4'h0;
            fault       <= 1'b0;
        end else begin
            state   <= state_nxt;
            hall_p0 <= hall;
            hall_p1 <= hall_p0;
            hall_p2 <= hall_p1;
            wd_cnt  <= (state_nxt != state) ? '0 : wd_cnt + WD_W'(1);

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                count  <= count + CW'(1);
            end else if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                count  <= count - CW'(1);
            end

            if (clr_undeliv)       undelivered <= '0;
            else if (load_undeliv) undelivered <= count;

            if (set_ret)      returning <= 1'b1;
            else if (clr_ret) returning <= 1'b0;

            en_tracking <= o_tracking;
            en_uturn    <= o_uturn;
            en_brake    <= o_brake;
            en_reverse  <= o_reverse;
            en_buzz     <= o_buzz;
            en_object   <= o_object;
            en_station  <= o_station;
            ssd_state   <= o_ssd;
            fault       <= o_fault;
        end
    end

    // Colour storage carries no reset; count gates its visibility
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= object_color;
    end

endmodule

// File: tb/tb_delivery_sequencer.sv
module tb_delivery_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hall = 1'b1;
    logic       start = 1'b0;
    logic       fault_clr = 1'b0;
    logic [1:0] object_color = 2'd0;
    logic [1:0] station_color = 2'd0;
    logic       end_of_track = 1'b0;
    logic       uturn_finished = 1'b0;
    logic       brake_finished = 1'b0;
    logic       reverse_finished = 1'b0;
    logic       buzz_finished = 1'b0;
    logic       en_tracking, en_uturn, en_brake, en_reverse, en_buzz, en_object, en_station;
    logic [3:0] ssd_state;
    logic [1:0] cur_color;
    logic [2:0] queue_count, undelivered;
    logic       fault;

    int tests = 0;
    int fails = 0;

    delivery_sequencer #(.COLOR_W(2), .DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .hall(hall), .start(start), .fault_clr(fault_clr),
        .object_color(object_color), .station_color(station_color),
        .end_of_track(end_of_track), .uturn_finished(uturn_finished),
        .brake_finished(brake_finished), .reverse_finished(reverse_finished),
        .buzz_finished(buzz_finished),
        .en_tracking(en_tracking), .en_uturn(en_uturn), .en_brake(en_brake),
        .en_reverse(en_reverse), .en_buzz(en_buzz), .en_object(en_object),
        .en_station(en_station), .ssd_state(ssd_state), .cur_color(cur_color),
        .queue_count(queue_count), .undelivered(undelivered), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one-cycle low pulse; returns at the negedge after the state update
    task automatic hall_pulse();
        hall = 1'b0;
        @(negedge clk);
        hall = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [1:0] c);
        object_color = c;
        hall_pulse();
    endtask

    initial begin
        // reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ssd", 32'(ssd_state), 0);
        chk("rst_en_object", 32'(en_object), 1);
        chk("rst_en_others", 32'({en_tracking, en_uturn, en_brake, en_reverse, en_buzz, en_station}), 0);
        chk("rst_cur_color", 32'(cur_color), 0);
        chk("rst_count", 32'(queue_count), 0);
        chk("rst_undeliv", 32'(undelivered), 0);
        chk("rst_fault", 32'(fault), 0);

        // three-item delivery
        load(2'd1);
        chk("load1_count", 32'(queue_count), 1);
        chk("load1_head", 32'(cur_color), 1);
        load(2'd2);
        load(2'd3);
        chk("load3_count", 32'(queue_count), 3);
        chk("load3_head", 32'(cur_color), 1);
        chk("load3_ssd", 32'(ssd_state), 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("send_ssd", 32'(ssd_state), 1);
        chk("send_en", 32'({en_tracking, en_station, en_object}), 32'b110);
        station_color = 2'd1; @(negedge clk);
        chk("match1_ssd", 32'(ssd_state), 2);
        chk("match1_en", 32'({en_tracking, en_brake, en_buzz}), 32'b011);
        hall_pulse();
        chk("pop1_ssd", 32'(ssd_state), 1);
        chk("pop1_count", 32'(queue_count), 2);
        chk("pop1_head", 32'(cur_color), 2);
        station_color = 2'd2; @(negedge clk);
        chk("match2_ssd", 32'(ssd_state), 2);
        hall_pulse();
        chk("pop2_count", 32'(queue_count), 1);
        chk("pop2_head", 32'(cur_color), 3);
        station_color = 2'd3; @(negedge clk);
        chk("match3_ssd", 32'(ssd_state), 2);
        hall_pulse();
        chk("pop3_ssd", 32'(ssd_state), 8);
        chk("pop3_count", 32'(queue_count), 0);
        chk("pop3_head", 32'(cur_color), 0);
        chk("uturn_en", 32'({en_uturn, en_buzz}), 32'b10);
        uturn_finished = 1'b1; @(negedge clk); uturn_finished = 1'b0;
        chk("return_ssd", 32'(ssd_state), 9);
        chk("return_track", 32'(en_tracking), 1);
        end_of_track = 1'b1; @(negedge clk); end_of_track = 1'b0;
        chk("uturn2_ssd", 32'(ssd_state), 8);
        uturn_finished = 1'b1; @(negedge clk); uturn_finished = 1'b0;
        chk("reverse_ssd", 32'(ssd_state), 10);
        chk("reverse_en", 32'(en_reverse), 1);
        reverse_finished = 1'b1; @(negedge clk); reverse_finished = 1'b0;
        chk("home_ssd", 32'(ssd_state), 0);
        chk("home_en_object", 32'(en_object), 1);

        // no colour at the dock
        station_color = 2'd0;
        load(2'd0);
        chk("nocolor_ssd", 32'(ssd_state), 14);
        chk("nocolor_buzz", 32'(en_buzz), 1);
        buzz_finished = 1'b1; @(negedge clk); buzz_finished = 1'b0;
        chk("nocolor_back_ssd", 32'(ssd_state), 0);
        chk("nocolor_count", 32'(queue_count), 0);

        // fill to DEPTH, overflow, then abort at end of track
        load(2'd1); load(2'd2); load(2'd3); load(2'd1);
        chk("full_count", 32'(queue_count), 4);
        load(2'd2);
        chk("overflow_ssd", 32'(ssd_state), 14);
        chk("overflow_count", 32'(queue_count), 4);
        buzz_finished = 1'b1; @(negedge clk); buzz_finished = 1'b0;
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("send4_ssd", 32'(ssd_state), 1);
        end_of_track = 1'b1; @(negedge clk); end_of_track = 1'b0;
        chk("eot4_ssd", 32'(ssd_state), 7);
        chk("eot4_undeliv", 32'(undelivered), 4);
        chk("eot4_count", 32'(queue_count), 0);
        brake_finished = 1'b1; buzz_finished = 1'b1; @(negedge clk);
        brake_finished = 1'b0; buzz_finished = 1'b0;
        uturn_finished = 1'b1; @(negedge clk); uturn_finished = 1'b0;
        end_of_track = 1'b1; @(negedge clk); end_of_track = 1'b0;
        uturn_finished = 1'b1; @(negedge clk); uturn_finished = 1'b0;
        reverse_finished = 1'b1; @(negedge clk); reverse_finished = 1'b0;
        chk("eot4_home_ssd", 32'(ssd_state), 0);
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("empty_start_ssd", 32'(ssd_state), 14);
        chk("empty_start_undeliv", 32'(undelivered), 0);
        buzz_finished = 1'b1; @(negedge clk); buzz_finished = 1'b0;

        // two-item abort, then watchdog in UTURN
        load(2'd2); load(2'd3);
        start = 1'b1; @(negedge clk); start = 1'b0;
        end_of_track = 1'b1; @(negedge clk); end_of_track = 1'b0;
        chk("eot2_ssd", 32'(ssd_state), 7);
        chk("eot2_undeliv", 32'(undelivered), 2);
        chk("eot2_count", 32'(queue_count), 0);
        brake_finished = 1'b1; @(negedge clk);
        chk("eot2_brake_only", 32'(ssd_state), 7);
        buzz_finished = 1'b1; @(negedge clk);
        brake_finished = 1'b0; buzz_finished = 1'b0;
        chk("eot2_uturn_ssd", 32'(ssd_state), 8);
        repeat (15) @(negedge clk);
        chk("wd_cycle15_ssd", 32'(ssd_state), 8);
        @(negedge clk);
        chk("wd_fault_ssd", 32'(ssd_state), 15);
        chk("wd_fault_flag", 32'(fault), 1);
        chk("wd_fault_en", 32'({en_buzz, en_uturn, en_object}), 32'b100);
        fault_clr = 1'b1; @(negedge clk); fault_clr = 1'b0;
        chk("fault_clr_ssd", 32'(ssd_state), 0);
        chk("fault_clr_flag", 32'(fault), 0);

        // station match wins over end_of_track; reset mid-return
        load(2'd2);
        start = 1'b1; @(negedge clk); start = 1'b0;
        station_color = 2'd2; end_of_track = 1'b1; @(negedge clk);
        end_of_track = 1'b0; station_color = 2'd0;
        chk("prio_match_ssd", 32'(ssd_state), 2);
        hall_pulse();
        chk("prio_uturn_ssd", 32'(ssd_state), 8);
        uturn_finished = 1'b1; @(negedge clk); uturn_finished = 1'b0;
        chk("pre_rst_ssd", 32'(ssd_state), 9);
        rst = 1'b0;
        #1;
        chk("midrst_ssd", 32'(ssd_state), 0);
        chk("midrst_en", 32'({en_tracking, en_object}), 32'b01);
        chk("midrst_count", 32'(queue_count), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ssd", 32'(ssd_state), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
